// File: rtl/data_mem_ctrl_if.sv
// data_mem_if: core-side data memory request/ready bus
interface data_mem_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ready;
    logic        mem_err;
    logic        mem_stall;
    modport master (
        output mem_ren, mem_wen, mem_addr, mem_be, mem_din,
        input  mem_dout, mem_ready, mem_err, mem_stall
    );
    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_be, mem_din,
        output mem_dout, mem_ready, mem_err, mem_stall
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: wait-state data memory controller with byte lanes, error flagging and debug counters
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    data_mem_if.slave   mem,
    input  logic [6:0]  debug_addr,
    output logic [31:0] debug_data
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t                state;
    logic [3:0]            cnt;
    logic                  op_wr;
    logic [31:0]           op_addr;
    logic [31:0]           op_din;
    logic [3:0]            op_be;
    logic [CNT_WIDTH-1:0]  rd_cnt;
    logic [CNT_WIDTH-1:0]  wr_cnt;
    logic [CNT_WIDTH-1:0]  err_cnt;
    logic [31:0]           ram [2**ADDR_WIDTH];
    logic                  req;
    logic                  cur_wr;
    logic [31:0]           cur_addr;
    logic                  cur_err;
    logic                  op_err;
    logic                  finishing;
    assign req = mem.mem_ren | mem.mem_wen;
    assign mem.mem_stall = req & ~mem.mem_ready;
    // With zero wait states the access completes straight from IDLE, so the live request is used
    always_comb begin
        cur_wr    = state == IDLE ? mem.mem_wen : op_wr;
        cur_addr  = state == IDLE ? mem.mem_addr : op_addr;
        cur_err   = |cur_addr[1:0] || |cur_addr[31:ADDR_WIDTH+2];
        op_err    = |op_addr[1:0] || |op_addr[31:ADDR_WIDTH+2];
        finishing = state == IDLE ? (WAIT_STATES == 0 && req) : (state == WAIT && cnt == 4'd0);
    end
    // Request FSM; ready/err/dout are registered on the edge entering DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            op_wr        <= 1'b0;
            op_addr      <= 32'd0;
            op_din       <= 32'd0;
            op_be        <= 4'd0;
            mem.mem_ready <= 1'b0;
            mem.mem_err   <= 1'b0;
            mem.mem_dout  <= 32'd0;
        end else begin
            mem.mem_ready <= finishing;
            mem.mem_err   <= finishing & cur_err;
            if (finishing && (cur_err || !cur_wr))
                mem.mem_dout <= cur_err ? 32'd0 : ram[cur_addr[ADDR_WIDTH+1:2]];
            case (state)
                IDLE: if (req) begin
                    op_wr   <= mem.mem_wen;
                    op_addr <= mem.mem_addr;
                    op_be   <= mem.mem_be;
                    op_din  <= mem.mem_din;
                    cnt     <= 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
                    state   <= WAIT_STATES == 0 ? DONE : WAIT;
                end
                WAIT: begin
                    cnt   <= cnt == 4'd0 ? cnt : cnt - 4'd1;
                    state <= cnt == 4'd0 ? DONE : WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Byte-lane commit at the end of DONE; a reset in that cycle suppresses it
    always_ff @(posedge clk) begin
        if (rst && state == DONE && op_wr && !op_err)
            for (int i = 0; i < 4; i++)
                if (op_be[i]) ram[op_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= op_din[8*i +: 8];
    end
    // Saturating access counters, bumped as DONE retires
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (state == DONE) begin
            if (op_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
            if (!op_err && op_wr && !(&wr_cnt)) wr_cnt <= wr_cnt + 1'b1;
            if (!op_err && !op_wr && !(&rd_cnt)) rd_cnt <= rd_cnt + 1'b1;
        end
    end
    // Registered debug mux; array reads see the pre-write word in a write's DONE cycle
    always_ff @(posedge clk) begin
        if (!rst) debug_data <= 32'd0;
        else debug_data <= debug_addr[6]        ? ram[ADDR_WIDTH'(debug_addr[5:0])] :
                           debug_addr == 7'h00 ? 32'(rd_cnt) :
                           debug_addr == 7'h01 ? 32'(wr_cnt) :
                           debug_addr == 7'h02 ? 32'(err_cnt) :
                           debug_addr == 7'h03 ? {state, cnt, 26'd0} : 32'd0;
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboarded directed bench for data_mem_ctrl
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  dbg1 = 7'd0;
    logic [6:0]  dbg0 = 7'd0;
    logic [31:0] dd1;
    logic [31:0] dd0;
    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb [$];
    logic [31:0] model [int];
    logic [31:0] last_dout = 32'd0;
    always #5 clk = ~clk;
    data_mem_if if1();
    data_mem_if if0();
    data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .mem(if1), .debug_addr(dbg1), .debug_data(dd1));
    data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .mem(if0), .debug_addr(dbg0), .debug_data(dd0));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Scoreboard: every completion on dut1 must match the oldest queued expectation
    always @(negedge clk) begin
        if (if1.mem_ready === 1'b1) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("sb_dout", if1.mem_dout, e[31:0]);
                chk("sb_err", {31'd0, if1.mem_err}, {31'd0, e[32]});
            end
        end
    end
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d, input int exp_lat);
        logic        e;
        logic [31:0] ed;
        logic [31:0] m;
        int          lat;
        e = (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
        if (e) ed = 32'd0;
        else if (w) begin
            m = model.exists(int'(a[31:2])) ? model[int'(a[31:2])] : 32'd0;
            for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = d[8*i +: 8];
            model[int'(a[31:2])] = m;
            ed = last_dout;
        end else ed = model[int'(a[31:2])];
        last_dout = ed;
        sb.push_back({e, ed});
        @(negedge clk);
        if1.mem_ren = r; if1.mem_wen = w; if1.mem_addr = a; if1.mem_be = be; if1.mem_din = d;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (if1.mem_ready !== 1'b1 && lat < 50);
        chk("latency", lat, exp_lat);
        if1.mem_ren = 1'b0; if1.mem_wen = 1'b0;
        @(posedge clk);
    endtask
    task automatic dbg(input logic [6:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        dbg1 = a;
        @(posedge clk); #1;
        chk(tag, dd1, exp);
    endtask
    initial begin
        if1.mem_ren = 0; if1.mem_wen = 0; if1.mem_addr = 0; if1.mem_be = 0; if1.mem_din = 0;
        if0.mem_ren = 0; if0.mem_wen = 0; if0.mem_addr = 0; if0.mem_be = 0; if0.mem_din = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_ready", {31'd0, if1.mem_ready}, 32'd0);
        chk("rst_err", {31'd0, if1.mem_err}, 32'd0);
        chk("rst_dout", if1.mem_dout, 32'd0);
        chk("rst_debug", dd1, 32'd0);
        access(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 2);
        access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 2);
        chk("rd_dout_const", if1.mem_dout, 32'hDEADBEEF);
        dbg(7'h00, 32'd1, "rd_cnt");
        dbg(7'h01, 32'd1, "wr_cnt");
        access(1'b0, 1'b1, 32'h20, 4'hF, 32'h11223344, 2);
        access(1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 2);
        access(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 2);
        dbg(7'h48, 32'h11BB33DD, "lane_word");
        access(1'b1, 1'b0, 32'h13, 4'h0, 32'h0, 2);
        access(1'b0, 1'b1, 32'h1000, 4'hF, 32'h55555555, 2);
        dbg(7'h02, 32'd2, "err_cnt");
        dbg(7'h44, 32'hDEADBEEF, "err_word4");
        dbg(7'h48, 32'h11BB33DD, "err_word8");
        access(1'b0, 1'b1, 32'h8, 4'hF, 32'hCAFEF00D, 2);
        @(negedge clk);
        if1.mem_wen = 1'b1; if1.mem_addr = 32'h8; if1.mem_be = 4'hF; if1.mem_din = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0; if1.mem_wen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        last_dout = 32'd0;
        chk("abort_ready", {31'd0, if1.mem_ready}, 32'd0);
        chk("abort_dout", if1.mem_dout, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_ready", {31'd0, if1.mem_ready}, 32'd0);
        end
        dbg(7'h00, 32'd0, "abort_rd_cnt");
        dbg(7'h01, 32'd0, "abort_wr_cnt");
        dbg(7'h02, 32'd0, "abort_err_cnt");
        dbg(7'h42, 32'hCAFEF00D, "abort_word2");
        for (int i = 0; i < 20; i++) access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 2);
        dbg(7'h00, 32'h0000000F, "rd_sat");
        access(1'b1, 1'b1, 32'h24, 4'hF, 32'h0BADCAFE, 2);
        chk("both_dout_kept", if1.mem_dout, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h24, 4'h0, 32'h0, 2);
        dbg(7'h01, 32'd1, "both_wr_cnt");
        @(negedge clk);
        if0.mem_wen = 1'b1; if0.mem_addr = 32'h4; if0.mem_be = 4'hF; if0.mem_din = 32'h12345678;
        #1 chk("ws0_stall_req", {31'd0, if0.mem_stall}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("ws0_ready", {31'd0, if0.mem_ready}, {31'd0, i % 2 == 0});
            chk("ws0_stall", {31'd0, if0.mem_stall}, {31'd0, i % 2 != 0});
        end
        if0.mem_wen = 1'b0; if0.mem_ren = 1'b1;
        @(posedge clk); #1;
        chk("ws0_rd_ready", {31'd0, if0.mem_ready}, 32'd1);
        chk("ws0_rd_dout", if0.mem_dout, 32'h12345678);
        if0.mem_ren = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
